// File: rtl/alu_input_ctrl_if.sv
// Operator-side bus between board buttons/switches and the ALU register stage.
// Handshake: the stage has no back-pressure. A strobe is valid for exactly one cycle, and data_in is sampled on the rising edge that closes that cycle.
interface alu_input_ctrl_if #(
  parameter int N = 16
);
  logic         btn_enter;
  logic         btn_undo;
  logic [N-1:0] sw;
  logic [N-1:0] data_in;
  logic         load_A;
  logic         load_B;
  logic         load_Op;
  logic         updateRes;
  logic [3:0]   state_led;

  modport master (
    output btn_enter, btn_undo, sw,
    input  data_in, load_A, load_B, load_Op, updateRes, state_led
  );

  modport slave (
    input  btn_enter, btn_undo, sw,
    output data_in, load_A, load_B, load_Op, updateRes, state_led
  );
endinterface

// File: rtl/alu_input_ctrl.sv
// Debounces the Enter and Undo buttons and steps the operand A -> B -> opcode -> result sequence,
// issuing one-cycle load strobes to the ALU register stage.
module alu_input_ctrl #(
  parameter int N         = 16,
  parameter int DB_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset,
  alu_input_ctrl_if.slave  bus
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  typedef enum logic [1:0] {S_A, S_B, S_OP, S_RES} state_t;

  // Bit 0 is Enter and bit 1 is Undo throughout the conditioning path.
  logic [1:0]    btn_raw;
  logic [1:0]    sync1_q;
  logic [1:0]    sync2_q;
  logic [1:0]    stable_q;
  logic [1:0]    stable_dly_q;
  logic [CW-1:0] cnt_q [2];
  logic [1:0]    press;
  logic          enter_go;
  logic          undo_go;

  state_t        state_q;
  state_t        state_d;
  logic          res_entry_q;
  logic [3:0]    led_q;
  logic [N-1:0]  sw_w;

  assign btn_raw = {bus.btn_undo, bus.btn_enter};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q      <= btn_raw;
      sync2_q      <= sync1_q;
      stable_dly_q <= stable_q;
      // A mismatch must persist for DB_CYCLES consecutive cycles before it is accepted.
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == stable_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CW'(DB_CYCLES - 1)) begin
          stable_q[i] <= sync2_q[i];
          cnt_q[i]    <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign press    = stable_q & ~stable_dly_q;
  assign enter_go = press[0] & ~press[1];
  assign undo_go  = press[1] & ~press[0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_A:   if (enter_go) state_d = S_B;
      S_B:   if (enter_go) state_d = S_OP;  else if (undo_go) state_d = S_A;
      S_OP:  if (enter_go) state_d = S_RES; else if (undo_go) state_d = S_B;
      S_RES: if (enter_go) state_d = S_A;   else if (undo_go) state_d = S_OP;
      default: state_d = S_A;
    endcase
  end

  function automatic logic [3:0] led_of(input state_t s);
    case (s)
      S_A:     led_of = 4'b0001;
      S_B:     led_of = 4'b0010;
      S_OP:    led_of = 4'b0100;
      S_RES:   led_of = 4'b1000;
      default: led_of = 4'b0001;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_A;
      res_entry_q <= 1'b0;
      led_q       <= 4'b0001;
    end else begin
      state_q     <= state_d;
      // S_RES is only reachable from S_OP via Enter, so this marks its entry cycle.
      res_entry_q <= (state_q == S_OP) && enter_go;
      led_q       <= led_of(state_d);
    end
  end

  assign sw_w          = bus.sw;
  assign bus.data_in   = sw_w;
  assign bus.load_A    = (state_q == S_A)  && enter_go;
  assign bus.load_B    = (state_q == S_B)  && enter_go;
  assign bus.load_Op   = (state_q == S_OP) && enter_go;
  assign bus.updateRes = res_entry_q;
  assign bus.state_led = led_q;

endmodule

// File: tb/tb_alu_input_ctrl.sv
// Bench for alu_input_ctrl with a short debounce window: table-driven press sequence plus
// hand-written glitch, latency and reset-during-debounce sequences.
module tb_alu_input_ctrl;

  localparam int N  = 16;
  localparam int DB = 4;
  localparam int EW = N + 4;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   cyc;
  int   last_strobe_cyc;
  int   strobe_cnt;

  logic [EW-1:0] exp_q[$];

  alu_input_ctrl_if #(.N(N)) bus ();

  alu_input_ctrl #(.N(N), .DB_CYCLES(DB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] op;          // 0 = enter, 1 = undo, 2 = both together
    logic [N-1:0] sw;
    logic [3:0] exp_led;
    logic [3:0] exp_strobe;  // {updateRes, load_Op, load_B, load_A}
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_strobes(input logic [3:0] mask, input logic [N-1:0] swv);
    for (int b = 0; b < 4; b++)
      if (mask[b]) exp_q.push_back({4'(1 << b), swv});
  endtask

  // Driver: hold the button(s) long enough to debounce, then release fully.
  task automatic do_press(input logic [1:0] op, input logic [N-1:0] swv, input logic [3:0] mask);
    bus.sw = swv;
    push_strobes(mask, swv);
    bus.btn_enter = (op != 2'd1);
    bus.btn_undo  = (op != 2'd0);
    repeat (12) @(negedge clk);
    bus.btn_enter = 1'b0;
    bus.btn_undo  = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  // Scoreboard: every strobe the DUT raises must match the head of the expected queue.
  always @(negedge clk) begin
    logic [3:0] st;
    logic [EW-1:0] got;
    logic [EW-1:0] exp;
    st = {bus.updateRes, bus.load_Op, bus.load_B, bus.load_A};
    if (!reset && st != 4'b0) begin
      strobe_cnt++;
      last_strobe_cyc = cyc;
      got = {st, bus.data_in};
      check("strobe_onehot", 32'($onehot(st)), 32'd1);
      check("data_in_passthru", 32'(bus.data_in), 32'(bus.sw));
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 32'(got), 32'd0);
      end else begin
        exp = exp_q.pop_front();
        check("strobe_event", 32'(got), 32'(exp));
      end
    end
  end

  initial begin
    int t0;
    int n0;
    checks = 0;
    failures = 0;
    cyc = 0;
    last_strobe_cyc = 0;
    strobe_cnt = 0;

    vecs[0]  = '{2'd0, 16'h0005, 4'b0010, 4'b0001};
    vecs[1]  = '{2'd0, 16'h0003, 4'b0100, 4'b0010};
    vecs[2]  = '{2'd0, 16'h0000, 4'b1000, 4'b1100};
    vecs[3]  = '{2'd1, 16'h0000, 4'b0100, 4'b0000};
    vecs[4]  = '{2'd1, 16'h0000, 4'b0010, 4'b0000};
    vecs[5]  = '{2'd1, 16'h0000, 4'b0001, 4'b0000};
    vecs[6]  = '{2'd1, 16'h0000, 4'b0001, 4'b0000};
    vecs[7]  = '{2'd0, 16'h1234, 4'b0010, 4'b0001};
    vecs[8]  = '{2'd2, 16'h5555, 4'b0010, 4'b0000};
    vecs[9]  = '{2'd0, 16'habcd, 4'b0100, 4'b0010};
    vecs[10] = '{2'd0, 16'h0001, 4'b1000, 4'b1100};
    vecs[11] = '{2'd0, 16'h0002, 4'b0001, 4'b0000};
    vecs[12] = '{2'd0, 16'($urandom_range(16'hffff)), 4'b0010, 4'b0001};
    vecs[13] = '{2'd0, 16'($urandom_range(16'hffff)), 4'b0100, 4'b0010};
    vecs[14] = '{2'd0, 16'h0003, 4'b1000, 4'b1100};
    vecs[15] = '{2'd0, 16'h0007, 4'b0001, 4'b0000};

    reset = 1'b1;
    bus.btn_enter = 1'b0;
    bus.btn_undo  = 1'b0;
    bus.sw        = '0;
    repeat (3) @(negedge clk);
    check("reset_led", 32'(bus.state_led), 32'h1);
    check("reset_strobes", 32'({bus.updateRes, bus.load_Op, bus.load_B, bus.load_A}), 32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      do_press(vecs[i].op, vecs[i].sw, vecs[i].exp_strobe);
      check($sformatf("vec%0d_led", i), 32'(bus.state_led), 32'(vecs[i].exp_led));
      check($sformatf("vec%0d_drained", i), 32'(exp_q.size()), 32'd0);
    end

    // Glitchy Enter: 3 high, 1 low, 3 high never survives the debounce window.
    n0 = strobe_cnt;
    bus.btn_enter = 1'b1; repeat (3) @(negedge clk);
    bus.btn_enter = 1'b0; repeat (1) @(negedge clk);
    bus.btn_enter = 1'b1; repeat (3) @(negedge clk);
    bus.btn_enter = 1'b0; repeat (12) @(negedge clk);
    check("glitch_led", 32'(bus.state_led), 32'h1);
    check("glitch_no_strobe", 32'(strobe_cnt - n0), 32'd0);

    // Steady hold: one load_A, seen in the cycle DB+2 edges after the rise is driven.
    bus.sw = 16'h00a5;
    push_strobes(4'b0001, 16'h00a5);
    n0 = strobe_cnt;
    t0 = cyc;
    bus.btn_enter = 1'b1;
    repeat (50) @(negedge clk);
    check("hold_one_strobe", 32'(strobe_cnt - n0), 32'd1);
    check("hold_latency", 32'(last_strobe_cyc - t0), 32'(DB + 2));
    check("hold_led", 32'(bus.state_led), 32'h2);
    bus.btn_enter = 1'b0;
    repeat (12) @(negedge clk);

    // Reset in S_OP while Enter is mid-debounce, button still held afterwards.
    do_press(2'd0, 16'h0042, 4'b0010);
    check("pre_reset_led", 32'(bus.state_led), 32'h4);
    bus.btn_enter = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #2;
    check("async_reset_led", 32'(bus.state_led), 32'h1);
    check("async_reset_strobes", 32'({bus.updateRes, bus.load_Op, bus.load_B, bus.load_A}), 32'h0);
    repeat (2) @(negedge clk);
    bus.sw = 16'h0099;
    push_strobes(4'b0001, 16'h0099);
    n0 = strobe_cnt;
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("post_reset_one_press", 32'(strobe_cnt - n0), 32'd1);
    check("post_reset_led", 32'(bus.state_led), 32'h2);
    bus.btn_enter = 1'b0;
    repeat (12) @(negedge clk);

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
